// File: rtl/rf_sched_pkg.sv
// Shared types and helpers for the register-file issue scheduler.
// Defines the register count, the scheduler state encoding and a one-hot decoder.
package rf_sched_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } sched_state_t;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rf_busy_table.sv
// Per-register busy scoreboard: one bit per register, set at issue, cleared at writeback.
// R0 is never marked busy; a same-cycle set and clear of one bit leaves it set.
module rf_busy_table
  import rf_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [NUM_REGS-1:0] clr_vec,
  output logic [NUM_REGS-1:0] busy_next
);

  localparam logic [NUM_REGS-1:0] R0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [NUM_REGS-1:0] set_vec;

  // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    set_vec   = '0;
    clr_vec   = '0;
    if (set_en) set_vec = onehot(set_addr) & R0_MASK;
    if (clr_en) clr_vec = onehot(clr_addr) & R0_MASK;
    // Clear first, then OR in the set, so the set wins on a collision.
    busy_next = (busy_mask & ~clr_vec) | set_vec;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: this is a flop vector rather than a RAM, so it takes the async reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_mask <= '0;
    else     busy_mask <= busy_next;
  end

endmodule

// File: rtl/rf_hazard_scheduler.sv
// ID-stage issue scheduler: stalls decode on RAW/WAW hazards against the busy scoreboard
// and sequences HLT through a drain of outstanding writes before asserting halted.
module rf_hazard_scheduler
  import rf_sched_pkg::*;
#(
  parameter bit BYPASS_WB = 1'b1,
  parameter int DRAIN_TMO = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [ADDR_W-1:0]   id_p0_addr,
  input  logic                id_re0,
  input  logic [ADDR_W-1:0]   id_p1_addr,
  input  logic                id_re1,
  input  logic [ADDR_W-1:0]   id_dst_addr,
  input  logic                id_we,
  input  logic                id_hlt,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_dst_addr,
  output logic                issue,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                halted,
  output logic                err_spurious,
  output logic                err_timeout
);

  localparam logic [7:0] TMO_CNT = 8'(DRAIN_TMO);

  sched_state_t        state;
  logic [7:0]          drain_cnt;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_next;
  logic [NUM_REGS-1:0] eff_busy;
  logic                hazard;
  logic                in_run;
  logic                set_en;
  logic                spurious;

  rf_busy_table u_busy_table (
    .clk       (clk),
    .rst       (rst),
    .set_en    (set_en),
    .set_addr  (id_dst_addr),
    .clr_en    (wb_valid),
    .clr_addr  (wb_dst_addr),
    .busy_mask (busy_mask),
    .clr_vec   (clr_vec),
    .busy_next (busy_next)
  );

  // Bit 0 of the scoreboard is never set, so R0 operands cannot raise a hazard.
  always_comb begin
    eff_busy = BYPASS_WB ? (busy_mask & ~clr_vec) : busy_mask;
    hazard   = (id_re0 & eff_busy[id_p0_addr])
             | (id_re1 & eff_busy[id_p1_addr])
             | (id_we  & eff_busy[id_dst_addr]);
    in_run   = (state == RUN);
    issue    = id_valid & in_run & ~hazard;
    stall    = id_valid & ~(in_run & ~hazard);
    set_en   = issue & id_we & ~id_hlt;
    spurious = wb_valid & (wb_dst_addr != '0) & ~busy_mask[wb_dst_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      drain_cnt    <= '0;
      halted       <= 1'b0;
      err_spurious <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (spurious) err_spurious <= 1'b1;
      case (state)
        RUN: begin
          if (issue && id_hlt) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          // Saturating count; the timeout flags but does not abandon the drain.
          if (drain_cnt != TMO_CNT) drain_cnt <= drain_cnt + 8'd1;
          if (drain_cnt == TMO_CNT - 8'd1) err_timeout <= 1'b1;
          if (busy_next == '0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: halted <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_hazard_scheduler.sv
// Self-checking bench for rf_hazard_scheduler: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a behavioural scoreboard model.
module tb_rf_hazard_scheduler;

  localparam int TMO = 64;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_p0_addr;
  logic        id_re0;
  logic [3:0]  id_p1_addr;
  logic        id_re1;
  logic [3:0]  id_dst_addr;
  logic        id_we;
  logic        id_hlt;
  logic        wb_valid;
  logic [3:0]  wb_dst_addr;
  logic        issue;
  logic        stall;
  logic [15:0] busy_mask;
  logic        halted;
  logic        err_spurious;
  logic        err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: busy set as a plain bit array, phase as 0=run 1=drain 2=halted.
  bit [15:0] m_busy;
  int        m_phase;
  int        m_drain_cycles;
  bit        m_esp, m_eto;
  bit        m_issue, m_stall;

  rf_hazard_scheduler #(.BYPASS_WB(1'b1), .DRAIN_TMO(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_p0_addr   (id_p0_addr),
    .id_re0       (id_re0),
    .id_p1_addr   (id_p1_addr),
    .id_re1       (id_re1),
    .id_dst_addr  (id_dst_addr),
    .id_we        (id_we),
    .id_hlt       (id_hlt),
    .wb_valid     (wb_valid),
    .wb_dst_addr  (wb_dst_addr),
    .issue        (issue),
    .stall        (stall),
    .busy_mask    (busy_mask),
    .halted       (halted),
    .err_spurious (err_spurious),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit reg_busy_after_wb(input int a);
    // A register being written back this cycle no longer counts as busy.
    if (a == 0) return 1'b0;
    if (wb_valid && int'(wb_dst_addr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_eval();
    bit haz;
    haz = (id_re0 && reg_busy_after_wb(int'(id_p0_addr)))
       || (id_re1 && reg_busy_after_wb(int'(id_p1_addr)))
       || (id_we  && reg_busy_after_wb(int'(id_dst_addr)));
    m_issue = id_valid && m_phase == 0 && !haz;
    m_stall = id_valid && !m_issue;
  endtask

  task automatic model_update();
    int wa;
    int da;
    wa = int'(wb_dst_addr);
    da = int'(id_dst_addr);
    if (wb_valid && wa != 0) begin
      if (!m_busy[wa]) m_esp = 1'b1;
      m_busy[wa] = 1'b0;
    end
    if (m_issue && id_we && !id_hlt && da != 0) m_busy[da] = 1'b1;
    case (m_phase)
      0: if (m_issue && id_hlt) begin m_phase = 1; m_drain_cycles = 0; end
      1: begin
        m_drain_cycles++;
        if (m_drain_cycles >= TMO) m_eto = 1'b1;
        if (m_busy == 16'h0) m_phase = 2;
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_busy = '0; m_phase = 0; m_drain_cycles = 0; m_esp = 0; m_eto = 0;
  endtask

  // One clock: compare every output against the model, then advance both past the edge.
  task automatic cyc();
    #1;
    model_eval();
    check("issue",        issue,        m_issue);
    check("stall",        stall,        m_stall);
    check("busy_mask",    busy_mask,    m_busy);
    check("halted",       halted,       m_phase == 2);
    check("err_spurious", err_spurious, m_esp);
    check("err_timeout",  err_timeout,  m_eto);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input int p0, input bit r0, input int p1, input bit r1,
                        input int dst, input bit we, input bit hlt);
    id_valid = v; id_p0_addr = 4'(p0); id_re0 = r0; id_p1_addr = 4'(p1); id_re1 = r1;
    id_dst_addr = 4'(dst); id_we = we; id_hlt = hlt;
  endtask

  task automatic set_wb(input bit v, input int a);
    wb_valid = v; wb_dst_addr = 4'(a);
  endtask

  // Reset asserted between clock edges; effects must be visible before the next edge.
  task automatic async_reset();
    set_id(1, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    #2 rst = 1'b1;
    #1;
    check("rst busy_mask",    busy_mask,    16'h0);
    check("rst halted",       halted,       1'b0);
    check("rst err_spurious", err_spurious, 1'b0);
    check("rst err_timeout",  err_timeout,  1'b0);
    check("rst stall",        stall,        1'b0);
    check("rst issue",        issue,        1'b1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc();

    // RAW on R3, cleared by a same-cycle writeback.
    set_id(1, 0, 0, 0, 0, 3, 1, 0); cyc();
    check("raw busy", busy_mask, 16'h0008);
    set_id(1, 3, 1, 0, 0, 1, 0, 0); #1;
    check("raw stall", stall, 1'b1);
    check("raw issue", issue, 1'b0);
    cyc();
    set_wb(1, 3); #1;
    check("raw bypass issue", issue, 1'b1);
    cyc();
    set_wb(0, 0);
    check("raw cleared", busy_mask, 16'h0);

    // WAW collision on R5: set wins over clear.
    set_id(1, 0, 0, 0, 0, 5, 1, 0); cyc();
    set_wb(1, 5); #1;
    check("waw issue", issue, 1'b1);
    cyc();
    check("waw busy5", busy_mask, 16'h0020);
    set_id(0, 0, 0, 0, 0, 0, 0, 0); cyc();
    set_wb(0, 0); cyc();

    // R0 is never busy and never spurious.
    set_id(1, 0, 0, 0, 0, 0, 1, 0); cyc();
    check("r0 busy", busy_mask, 16'h0);
    set_id(1, 0, 1, 0, 1, 0, 0, 0); #1;
    check("r0 stall", stall, 1'b0);
    cyc();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); set_wb(1, 0); cyc();
    set_wb(0, 0);
    check("r0 spurious", err_spurious, 1'b0);

    // Halt drain with R2 and R7 outstanding.
    set_id(1, 0, 0, 0, 0, 2, 1, 0); cyc();
    set_id(1, 0, 0, 0, 0, 7, 1, 0); cyc();
    check("drain busy", busy_mask, 16'h0084);
    set_id(1, 0, 0, 0, 0, 0, 0, 1); cyc();
    set_id(1, 1, 1, 0, 0, 0, 0, 0); #1;
    check("drain stall", stall, 1'b1);
    set_wb(1, 2); cyc();
    set_wb(1, 7); cyc();
    check("halted after r7", halted, 1'b1);
    set_wb(0, 0); cyc();
    check("halted stall", stall, 1'b1);

    // Drain timeout with R4 outstanding.
    async_reset();
    set_id(1, 0, 0, 0, 0, 4, 1, 0); cyc();
    set_id(1, 0, 0, 0, 0, 0, 0, 1); cyc();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (TMO - 1) cyc();
    check("tmo not yet", err_timeout, 1'b0);
    cyc();
    check("tmo set", err_timeout, 1'b1);
    check("tmo halted", halted, 1'b0);
    set_wb(1, 4); cyc();
    set_wb(0, 0);
    check("tmo then halted", halted, 1'b1);
    check("tmo sticky", err_timeout, 1'b1);

    // Reset mid-drain, then a spurious writeback.
    async_reset();
    set_id(1, 0, 0, 0, 0, 6, 1, 0); cyc();
    set_id(1, 0, 0, 0, 0, 0, 0, 1); cyc();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); cyc();
    async_reset();
    set_wb(1, 9); cyc();
    set_wb(0, 0); cyc();
    check("spurious r9", err_spurious, 1'b1);

    // Randomized traffic in several reset-separated segments.
    for (int seg = 0; seg < 4; seg++) begin
      async_reset();
      for (int c = 0; c < 350; c++) begin
        int k;
        set_id(($urandom % 4) != 0, int'($urandom % 8), 1'($urandom), int'($urandom % 8),
               1'($urandom), int'($urandom % 8), 1'($urandom),
               (seg > 0) && (($urandom % 60) == 0));
        wb_valid = ($urandom % 3) == 0;
        if (m_busy != 16'h0 && ($urandom % 8) != 0) begin
          k = int'($urandom % 16);
          while (!m_busy[k]) k = (k + 1) % 16;
          wb_dst_addr = 4'(k);
        end else begin
          wb_dst_addr = 4'($urandom % 16);
        end
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
